y86_wb_regfile: RTL and testbench

Parametrised write-back stage and register file for the pipelined Y86-64 core. It captures the memory-stage result into a W pipeline register, decodes the destinations (dstE/dstM) from icode/cnd, and commits valE/valM into a 15-entry register file on the next clock edge. It provides two combinational read ports with optional bypass from the W register, and tracks halt status and a retired-instruction count. It replaces the single-cycle combinational write-back used in the SEQ core.

---
 rtl/y86_wb_regfile_if.sv | 24 ++
 rtl/y86_wb_regfile.sv | 168 ++++++++++++++++
 tb/tb_y86_wb_regfile.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/y86_wb_regfile_if.sv
// M-to-W bundle for the Y86-64 write-back stage.
// The memory stage drives it; the write-back register file consumes it.
interface y86_wb_regfile_if #(
   parameter int XLEN = 64
);
   logic            m_valid;
   logic [3:0]      m_icode;
   logic            m_cnd;
   logic [3:0]      m_rA;
   logic [3:0]      m_rB;
   logic [XLEN-1:0] m_valE;
   logic [XLEN-1:0] m_valM;
   logic [2:0]      m_stat;

   modport master (
      output m_valid, m_icode, m_cnd, m_rA, m_rB,
      output m_valE, m_valM, m_stat
   );

   modport slave (
      input m_valid, m_icode, m_cnd, m_rA, m_rB,
      input m_valE, m_valM, m_stat
   );
endinterface

// File: rtl/y86_wb_regfile.sv
// Y86-64 write-back pipeline register and 15-entry register file.
// Captures M into W, commits W a cycle later, with optional read bypass.
module y86_wb_regfile #(
   parameter int XLEN   = 64,
   parameter bit BYPASS = 1'b1,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             w_stall,
   input  logic             w_bubble,
   y86_wb_regfile_if.slave  m,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [XLEN-1:0]  rdA,
   output logic [XLEN-1:0]  rdB,
   output logic [3:0]       w_dstE,
   output logic [3:0]       w_dstM,
   output logic [3:0]       w_icode,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] I_NOP = 4'h1;
   localparam logic [2:0] S_AOK = 3'd1;

   logic            w_valid_q, w_valid_d;
   logic [3:0]      w_icode_q, w_icode_d;
   logic [3:0]      w_dste_q,  w_dste_d;
   logic [3:0]      w_dstm_q,  w_dstm_d;
   logic [XLEN-1:0] w_vale_q,  w_vale_d;
   logic [XLEN-1:0] w_valm_q,  w_valm_d;
   logic [2:0]      w_stat_q,  w_stat_d;

   logic [XLEN-1:0] regs_q [15];
   logic [XLEN-1:0] regs_d [15];
   logic             halted_q,  halted_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic       commit;
   logic       commit_ok;
   logic       byp_en;
   logic [3:0] dec_dste;
   logic [3:0] dec_dstm;

   assign commit    = w_valid_q && !halted_q;
   assign commit_ok = commit && (w_stat_q == S_AOK);
   assign byp_en    = BYPASS && commit_ok;

   always_comb begin
      dec_dste = RNONE;
      case (m.m_icode)
         4'h2:    dec_dste = m.m_cnd ? m.m_rB : RNONE;
         4'h3,
         4'h6:    dec_dste = m.m_rB;
         4'h8,
         4'h9,
         4'hA,
         4'hB:    dec_dste = RRSP;
         default: dec_dste = RNONE;
      endcase
   end

   always_comb begin
      dec_dstm = RNONE;
      case (m.m_icode)
         4'h5,
         4'hB:    dec_dstm = m.m_rA;
         default: dec_dstm = RNONE;
      endcase
   end

   always_comb begin
      w_valid_d = w_valid_q;
      w_icode_d = w_icode_q;
      w_dste_d  = w_dste_q;
      w_dstm_d  = w_dstm_q;
      w_vale_d  = w_vale_q;
      w_valm_d  = w_valm_q;
      w_stat_d  = w_stat_q;
      if (halted_q) begin
         w_valid_d = w_valid_q;
      end else if (w_stall) begin
         // a held instruction commits once, then goes inert
         if (commit) w_valid_d = 1'b0;
      end else if (w_bubble || !m.m_valid) begin
         w_valid_d = 1'b0;
         w_icode_d = I_NOP;
         w_dste_d  = RNONE;
         w_dstm_d  = RNONE;
         w_vale_d  = '0;
         w_valm_d  = '0;
         w_stat_d  = S_AOK;
      end else begin
         w_valid_d = 1'b1;
         w_icode_d = m.m_icode;
         w_dste_d  = dec_dste;
         w_dstm_d  = dec_dstm;
         w_vale_d  = m.m_valE;
         w_valm_d  = m.m_valM;
         w_stat_d  = m.m_stat;
      end
   end

   always_comb begin
      regs_d    = regs_q;
      halted_d  = halted_q;
      retired_d = retired_q;
      if (commit_ok) begin
         if (w_dste_q != RNONE) regs_d[w_dste_q] = w_vale_q;
         // dstM written last so popq %rsp keeps the loaded value
         if (w_dstm_q != RNONE) regs_d[w_dstm_q] = w_valm_q;
         retired_d = retired_q + 1'b1;
      end else if (commit) begin
         halted_d = 1'b1;
      end
   end

   function automatic logic [XLEN-1:0] rd_port(input logic [3:0] s);
      logic [XLEN-1:0] r;
      r = '0;
      if (s == RNONE)                   r = '0;
      else if (byp_en && s == w_dstm_q) r = w_valm_q;
      else if (byp_en && s == w_dste_q) r = w_vale_q;
      else                              r = regs_q[s];
      return r;
   endfunction

   always_comb begin
      rdA = rd_port(srcA);
      rdB = rd_port(srcB);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_valid_q <= 1'b0;
         w_icode_q <= I_NOP;
         w_dste_q  <= RNONE;
         w_dstm_q  <= RNONE;
         w_vale_q  <= '0;
         w_valm_q  <= '0;
         w_stat_q  <= S_AOK;
         halted_q  <= 1'b0;
         retired_q <= '0;
         for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      end else begin
         w_valid_q <= w_valid_d;
         w_icode_q <= w_icode_d;
         w_dste_q  <= w_dste_d;
         w_dstm_q  <= w_dstm_d;
         w_vale_q  <= w_vale_d;
         w_valm_q  <= w_valm_d;
         w_stat_q  <= w_stat_d;
         halted_q  <= halted_d;
         retired_q <= retired_d;
         regs_q    <= regs_d;
      end
   end

   assign w_dstE  = w_dste_q;
   assign w_dstM  = w_dstm_q;
   assign w_icode = w_icode_q;
   assign halted  = halted_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed bench for y86_wb_regfile.
// Drives one bypassing and one non-bypassing instance from the same M bundle.
module tb_y86_wb_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        w_stall;
   logic        w_bubble;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [63:0] rdA1, rdB1, rdA0, rdB0;
   logic [3:0]  dste1, dstm1, icode1;
   logic [3:0]  dste0, dstm0, icode0;
   logic        halted1, halted0;
   logic [31:0] retired1, retired0;

   int n_chk = 0;
   int n_err = 0;

   y86_wb_regfile_if #(.XLEN(64)) mif ();

   always #5 clk = ~clk;

   y86_wb_regfile #(.XLEN(64), .BYPASS(1'b1), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .w_stall(w_stall), .w_bubble(w_bubble),
      .m(mif), .srcA(srcA), .srcB(srcB), .rdA(rdA1), .rdB(rdB1),
      .w_dstE(dste1), .w_dstM(dstm1), .w_icode(icode1),
      .halted(halted1), .retired(retired1)
   );

   y86_wb_regfile #(.XLEN(64), .BYPASS(1'b0), .CNT_W(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .w_stall(w_stall), .w_bubble(w_bubble),
      .m(mif), .srcA(srcA), .srcB(srcB), .rdA(rdA0), .rdB(rdB0),
      .w_dstE(dste0), .w_dstM(dstm0), .w_icode(icode0),
      .halted(halted0), .retired(retired0)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] ic, input logic cnd,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] ve, input logic [63:0] vm,
                      input logic [2:0] st);
      mif.m_valid = 1'b1;
      mif.m_icode = ic;
      mif.m_cnd   = cnd;
      mif.m_rA    = ra;
      mif.m_rB    = rb;
      mif.m_valE  = ve;
      mif.m_valM  = vm;
      mif.m_stat  = st;
   endtask

   initial begin
      rst_n    = 1'b0;
      w_stall  = 1'b0;
      w_bubble = 1'b0;
      srcA     = 4'h3;
      srcB     = 4'hF;
      put(4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1);
      mif.m_valid = 1'b0;
      tick();
      tick();
      chk("rst_dstE", dste1, 4'hF);
      chk("rst_dstM", dstm1, 4'hF);
      chk("rst_icode", icode1, 4'h1);
      chk("rst_halted", halted1, 1'b0);
      chk("rst_retired", retired1, 0);
      chk("rst_rdA", rdA1, 0);
      chk("rst_rdB_rnone", rdB1, 0);
      rst_n = 1'b1;

      put(4'h3, 1'b0, 4'hF, 4'h3, 64'h1234, 64'h0, 3'd1);
      tick();
      mif.m_valid = 1'b0;
      chk("irm_w_dstE", dste1, 4'h3);
      chk("irm_w_dstM", dstm1, 4'hF);
      chk("irm_w_icode", icode1, 4'h3);
      chk("irm_bypass", rdA1, 64'h1234);
      chk("irm_nobyp", rdA0, 0);
      chk("irm_ret0", retired1, 0);
      tick();
      chk("irm_reg3", rdA1, 64'h1234);
      chk("irm_reg3_nb", rdA0, 64'h1234);
      chk("irm_ret1", retired1, 1);
      chk("irm_bub_dstE", dste1, 4'hF);

      srcB = 4'h4;
      put(4'hB, 1'b0, 4'h4, 4'hF, 64'h108, 64'hDEAD, 3'd1);
      tick();
      mif.m_valid = 1'b0;
      chk("pop_dstE", dste1, 4'h4);
      chk("pop_dstM", dstm1, 4'h4);
      chk("pop_byp_valM", rdB1, 64'hDEAD);
      tick();
      chk("pop_reg4", rdB1, 64'hDEAD);
      chk("pop_reg4_nb", rdB0, 64'hDEAD);
      chk("pop_ret", retired1, 2);

      srcA = 4'h5;
      put(4'h2, 1'b0, 4'hF, 4'h5, 64'h7, 64'h0, 3'd1);
      tick();
      mif.m_valid = 1'b0;
      chk("cmov0_dstE", dste1, 4'hF);
      tick();
      chk("cmov0_reg5", rdA0, 0);
      chk("cmov0_ret", retired1, 3);
      put(4'h2, 1'b1, 4'hF, 4'h5, 64'h7, 64'h0, 3'd1);
      tick();
      mif.m_valid = 1'b0;
      chk("cmov1_dstE", dste1, 4'h5);
      tick();
      chk("cmov1_reg5", rdA0, 64'h7);
      chk("cmov1_ret", retired1, 4);

      srcA = 4'h6;
      put(4'h6, 1'b0, 4'hF, 4'h6, 64'h66, 64'h0, 3'd1);
      tick();
      w_stall = 1'b1;
      w_bubble = 1'b1;
      put(4'h6, 1'b0, 4'hF, 4'h6, 64'h77, 64'h0, 3'd1);
      chk("stall_byp", rdA1, 64'h66);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_reg6", rdA0, 64'h66);
         chk("stall_reg6_b", rdA1, 64'h66);
         chk("stall_ret", retired1, 5);
      end
      w_stall = 1'b0;
      tick();
      w_bubble = 1'b0;
      mif.m_valid = 1'b0;
      chk("bub_dstE", dste1, 4'hF);
      chk("bub_dstM", dstm1, 4'hF);
      chk("bub_icode", icode1, 4'h1);
      tick();
      chk("bub_reg6", rdA0, 64'h66);
      chk("bub_ret", retired1, 5);

      srcA = 4'h2;
      put(4'h5, 1'b0, 4'h2, 4'hF, 64'h0, 64'h9, 3'd3);
      tick();
      chk("adr_dstM", dstm1, 4'h2);
      chk("adr_nobyp", rdA1, 0);
      put(4'h6, 1'b0, 4'hF, 4'h2, 64'h22, 64'h0, 3'd1);
      tick();
      mif.m_valid = 1'b0;
      chk("adr_halted", halted1, 1'b1);
      chk("adr_ret", retired1, 5);
      chk("adr_reg2", rdA1, 0);
      tick();
      tick();
      chk("halt_reg2", rdA0, 0);
      chk("halt_reg2_b", rdA1, 0);
      chk("halt_ret", retired1, 5);
      chk("halt_sticky", halted0, 1'b1);

      rst_n = 1'b0;
      srcB = 4'h3;
      tick();
      chk("rst2_halted", halted1, 1'b0);
      chk("rst2_ret", retired1, 0);
      chk("rst2_reg3", rdB1, 0);
      rst_n = 1'b1;

      srcA = 4'h7;
      put(4'h3, 1'b0, 4'hF, 4'h7, 64'h77, 64'h0, 3'd1);
      tick();
      mif.m_valid = 1'b0;
      chk("r7_byp", rdA1, 64'h77);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("r7_reg7", rdA1, 0);
      chk("r7_reg7_nb", rdA0, 0);
      chk("r7_ret", retired1, 0);
      chk("r7_dstE", dste1, 4'hF);
      chk("r7_icode", icode1, 4'h1);
      chk("r7_halted", halted1, 1'b0);
      tick();
      chk("r7_late", rdA0, 0);
      chk("r7_late_ret", retired0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
